// File: rtl/number_entry_buffer.sv
// number_entry_buffer: keypad digit buffer with serial BCD-to-binary conversion on enter
module number_entry_buffer #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int CNT_W      = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [3:0]              selected_key,
  input  logic                    digit_pressed,
  input  logic                    backspace_pressed,
  input  logic                    enter_pressed,
  output logic [4*MAX_DIGITS-1:0] digits,
  output logic [CNT_W-1:0]        digit_count,
  output logic [VALUE_W-1:0]      value,
  output logic                    value_valid,
  output logic                    busy,
  output logic                    overflow
);
  localparam int DW = 4*MAX_DIGITS;
  localparam logic [0:0] ENTRY   = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;
  logic [0:0]         state_q, state_d;
  logic [DW-1:0]      digits_q, digits_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic [VALUE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DW-1:0]      sh;
  logic [VALUE_W-1:0] conv;
  // Next-state logic: enable gates everything, CONVERT ignores keys, ENTRY serves one key by priority
  always_comb begin
    sh       = digits_q >> {idx_q, 2'b00};
    conv     = acc_q * VALUE_W'(10) + VALUE_W'(sh[3:0]);
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    ovf_d    = 1'b0;
    acc_d    = acc_q;
    idx_d    = idx_q;
    if (!enable) begin
      state_d  = ENTRY;
      digits_d = '0;
      count_d  = '0;
    end else if (state_q == CONVERT) begin
      acc_d = conv;
      idx_d = idx_q - CNT_W'(1);
      if (idx_q == '0) begin
        value_d  = conv;
        valid_d  = 1'b1;
        digits_d = '0;
        count_d  = '0;
        state_d  = ENTRY;
      end
    end else if (enter_pressed) begin
      if (count_q != '0) begin
        state_d = CONVERT;
        acc_d   = '0;
        idx_d   = count_q - CNT_W'(1);
      end
    end else if (backspace_pressed) begin
      if (count_q != '0) begin
        digits_d = {4'b0000, digits_q[DW-1:4]};
        count_d  = count_q - CNT_W'(1);
      end
    end else if (digit_pressed && selected_key <= 4'd9) begin
      if (count_q < CNT_W'(MAX_DIGITS)) begin
        digits_d = {digits_q[DW-5:0], selected_key};
        count_d  = count_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end
  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ENTRY;
      digits_q <= '0;
      count_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
    end
  end
  assign digits      = digits_q;
  assign digit_count = count_q;
  assign value       = value_q;
  assign value_valid = valid_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == CONVERT);
endmodule

// File: tb/tb_number_entry_buffer.sv
// tb_number_entry_buffer: directed scoreboard bench for number_entry_buffer
module tb_number_entry_buffer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  selected_key = 4'd0;
  logic        digit_pressed = 1'b0;
  logic        backspace_pressed = 1'b0;
  logic        enter_pressed = 1'b0;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic [13:0] value;
  logic        value_valid;
  logic        busy;
  logic        overflow;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [13:0] sb[$];

  number_entry_buffer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .selected_key(selected_key),
    .digit_pressed(digit_pressed), .backspace_pressed(backspace_pressed),
    .enter_pressed(enter_pressed), .digits(digits), .digit_count(digit_count),
    .value(value), .value_valid(value_valid), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic b, input logic e, input logic [3:0] k);
    digit_pressed = d;
    backspace_pressed = b;
    enter_pressed = e;
    selected_key = k;
    @(posedge clk);
    #1;
    digit_pressed = 1'b0;
    backspace_pressed = 1'b0;
    enter_pressed = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_conv(input int exp_busy, input string tag);
    int n = 0;
    while (busy && n < 20) begin
      n++;
      idle();
    end
    chk({tag, "_busy_cycles"}, n, exp_busy);
    chk({tag, "_valid"}, value_valid, 1'b1);
    chk({tag, "_count0"}, digit_count, 0);
    chk({tag, "_digits0"}, digits, 0);
  endtask

  // Scoreboard: every value_valid pulse must match the oldest expected value
  always @(negedge clk) begin
    if (reset_n && value_valid) begin
      pulses++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_valid: observed value %0d with empty scoreboard", value);
      end
      if (sb.size() > 0) chk("sb_value", value, sb.pop_front());
    end
    if (reset_n && value_valid && overflow) begin
      checks++;
      errors++;
      $error("FAIL valid_ovf_excl: observed both high expected exclusive");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_digits", digits, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_value", value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", value_valid, 0);
    chk("rst_ovf", overflow, 0);
    #10 reset_n = 1'b1;
    enable = 1'b1;
    // 1,2,3,4 enter -> 1234
    step(1, 0, 0, 4'd1);
    step(1, 0, 0, 4'd2);
    step(1, 0, 0, 4'd3);
    step(1, 0, 0, 4'd4);
    chk("s1_digits", digits, 16'h1234);
    chk("s1_count", digit_count, 4);
    sb.push_back(14'd1234);
    step(0, 0, 1, 4'd11);
    finish_conv(4, "s1");
    chk("s1_value", value, 1234);
    idle();
    chk("s1_valid_one_cycle", value_valid, 0);
    chk("s1_value_hold", value, 1234);
    // 5,6,bs,7 enter -> 57
    step(1, 0, 0, 4'd5);
    chk("s2_count_a", digit_count, 1);
    step(1, 0, 0, 4'd6);
    chk("s2_count_b", digit_count, 2);
    step(0, 1, 0, 4'd10);
    chk("s2_count_c", digit_count, 1);
    chk("s2_digits_c", digits, 16'h0005);
    step(1, 0, 0, 4'd7);
    chk("s2_count_d", digit_count, 2);
    chk("s2_digits_d", digits, 16'h0057);
    sb.push_back(14'd57);
    step(0, 0, 1, 4'd11);
    finish_conv(2, "s2");
    chk("s2_value", value, 57);
    // five 9s -> overflow on fifth, then 9999
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 4'd9);
      chk("s3_no_ovf", overflow, 0);
    end
    step(1, 0, 0, 4'd9);
    chk("s3_ovf", overflow, 1);
    chk("s3_digits", digits, 16'h9999);
    chk("s3_count", digit_count, 4);
    idle();
    chk("s3_ovf_pulse", overflow, 0);
    sb.push_back(14'd9999);
    step(0, 0, 1, 4'd11);
    finish_conv(4, "s3");
    chk("s3_value", value, 9999);
    // empty-buffer enter/backspace and non-digit key
    step(0, 0, 1, 4'd11);
    chk("s4_enter_busy", busy, 0);
    chk("s4_enter_valid", value_valid, 0);
    step(0, 1, 0, 4'd10);
    chk("s4_bs_count", digit_count, 0);
    step(1, 0, 0, 4'd10);
    chk("s4_key10_count", digit_count, 0);
    chk("s4_key10_digits", digits, 0);
    chk("s4_key10_ovf", overflow, 0);
    // enable dropped on second CONVERT cycle
    step(1, 0, 0, 4'd4);
    step(1, 0, 0, 4'd2);
    step(0, 0, 1, 4'd11);
    chk("s5_busy_c1", busy, 1);
    idle();
    chk("s5_busy_c2", busy, 1);
    enable = 1'b0;
    idle();
    chk("s5_busy_fall", busy, 0);
    chk("s5_no_valid", value_valid, 0);
    chk("s5_value_kept", value, 9999);
    chk("s5_count", digit_count, 0);
    chk("s5_digits", digits, 0);
    enable = 1'b1;
    // enter beats digit; digits during CONVERT dropped
    step(1, 0, 0, 4'd3);
    step(1, 0, 0, 4'd8);
    sb.push_back(14'd38);
    step(1, 0, 1, 4'd5);
    chk("s6_enter_wins_busy", busy, 1);
    chk("s6_enter_wins_digits", digits, 16'h0038);
    step(1, 0, 0, 4'd1);
    finish_conv(1, "s6");
    chk("s6_value", value, 38);
    // reset mid-entry clears everything immediately
    step(1, 0, 0, 4'd7);
    step(1, 0, 0, 4'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("s7_digits", digits, 0);
    chk("s7_count", digit_count, 0);
    chk("s7_value", value, 0);
    chk("s7_busy", busy, 0);
    chk("s7_valid", value_valid, 0);
    chk("s7_ovf", overflow, 0);
    #3 reset_n = 1'b1;
    step(1, 0, 0, 4'd6);
    chk("s7_first_after_rst", digits, 16'h0006);
    chk("s7_count_after_rst", digit_count, 1);
    idle();
    chk("sb_drained", sb.size(), 0);
    chk("valid_pulses", pulses, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/number_entry_buffer.md
NUMBER_ENTRY_BUFFER -- requirements
Module: number_entry_buffer

Interface
REQ-001 Parameter MAX_DIGITS, default 4, is the maximum number of digits held in the buffer.
REQ-002 Parameter VALUE_W, default 14, is the width of the converted binary value, sized to hold 10^MAX_DIGITS-1.
REQ-003 Parameter CNT_W, default 3, is the width of digit_count, equal to $clog2(MAX_DIGITS+1).
REQ-004 Port clk  input  1  is the single system clock, and all state changes on its rising edge.
REQ-005 Port reset_n  input  1  is an asynchronous, active-low reset.
REQ-006 Port enable  input  1  is high when the entry screen is active.
REQ-007 Port selected_key  input  4  is the key code from the keypad stage: 0-9 are digits, 10 is backspace, 11 is enter.
REQ-008 Port digit_pressed  input  1  is a one-cycle pulse meaning a digit key was selected.
REQ-009 Port backspace_pressed  input  1  is a one-cycle pulse meaning backspace was selected.
REQ-010 Port enter_pressed  input  1  is a one-cycle pulse meaning enter was selected.
REQ-011 Port digits  output  4*MAX_DIGITS  holds the buffered BCD digits, with the most recent digit in nibble [3:0] and unused nibbles zero.
REQ-012 Port digit_count  output  CNT_W  is the number of digits currently buffered.
REQ-013 Port value  output  VALUE_W  is the last committed binary value.
REQ-014 Port value_valid  output  1  is a one-cycle pulse when value updates.
REQ-015 Port busy  output  1  is high while the state is CONVERT.
REQ-016 Port overflow  output  1  is a one-cycle pulse when a digit is rejected because the buffer is full.

Function
REQ-017 The FSM shall have two states: ENTRY and CONVERT.
REQ-018 In ENTRY with enable high, the block shall act on at most one input per cycle, with priority enter > backspace > digit.
REQ-019 When digit_pressed is high, selected_key <= 9 and digit_count < MAX_DIGITS, the block shall do all of the following on the next edge: digits <= {digits shifted left 4, selected_key}; digit_count increments.
REQ-020 When digit_pressed is high and digit_count == MAX_DIGITS, the buffer shall be unchanged and overflow shall pulse high for one cycle.
REQ-021 When digit_pressed is high and selected_key > 9, the block shall ignore the pulse with no change and no overflow.
REQ-022 When backspace_pressed is high and digit_count > 0, the block shall do all of the following on the next edge: digits <= digits shifted right 4 with zero fill; digit_count decrements.
REQ-023 When backspace_pressed is high and digit_count == 0, the block shall ignore the pulse.
REQ-024 When enter_pressed is high and digit_count > 0, the block shall do all of the following on the next edge (edge k): state -> CONVERT; acc <= 0; idx <= digit_count-1.
REQ-025 When enter_pressed is high and digit_count == 0, the block shall ignore the pulse and emit no value_valid.
REQ-026 In CONVERT, on each edge the block shall do both of the following: acc <= acc*10 + digits nibble[idx]; idx decrements.
REQ-027 On the CONVERT edge where idx == 0, the block shall do all of the following: value <= final acc; value_valid <= 1 for one cycle; digits <= 0; digit_count <= 0; state -> ENTRY.
REQ-028 Latency shall be digit_count edges after edge k, so the value_valid cycle follows edge k+digit_count.
REQ-029 All arithmetic shall be performed at VALUE_W bits, and no saturation shall be needed because the maximum is 10^MAX_DIGITS-1.
REQ-030 In CONVERT, digit, backspace and enter pulses shall be ignored and dropped, not queued.
REQ-031 busy shall be 1 exactly while the state is CONVERT.
REQ-032 When enable is low in any state, on the next edge the block shall do all of the following: digits <= 0; digit_count <= 0; state -> ENTRY; abort any conversion with no value_valid; leave value unchanged.
REQ-033 value shall hold its last committed result until the next value_valid or reset.
REQ-034 value_valid and overflow shall never both be high in the same cycle.

Reset
REQ-035 While reset_n is low, and asynchronously, the block shall set all of the following: state = ENTRY; digits = 0; digit_count = 0; value = 0; value_valid = 0; busy = 0; overflow = 0; acc = 0; idx = 0.
REQ-036 A reset asserted mid-CONVERT shall abort the conversion with no value_valid pulse.
REQ-037 After reset_n deasserts, the block shall accept the first pulse sampled on the following rising edge.

Verification
REQ-038 The bench shall cover this scenario: digits 1,2,3,4 then enter -> busy high for 4 cycles; value=1234 with one value_valid pulse; digit_count=0; digits=0.
REQ-039 The bench shall cover this scenario: digits 5,6, backspace, 7, enter -> value=57; digit_count goes 1,2,1,2.
REQ-040 The bench shall cover this scenario: 5 digits 9 -> fifth digit raises overflow for one cycle; digits=16'h9999; enter -> value=9999.
REQ-041 The bench shall cover this scenario: enter or backspace on an empty buffer -> no change; no value_valid; digit_pressed with key 10 -> ignored.
REQ-042 The bench shall cover this scenario: enable dropped on the second CONVERT cycle -> busy falls; no value_valid; value retains its previous value; buffer is empty.
REQ-043 The bench shall cover this scenario: enter and digit pulses in the same cycle with count 2 -> enter wins, and digit pulses during CONVERT are dropped; reset_n low mid-entry -> all outputs 0 immediately.
